key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_pkg.sv | 15 +
 rtl/key_sync_edge.sv | 31 +++
 rtl/key_filter.sv | 106 ++++++++++
 tb/tb_key_filter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the key debounce filter.
// Holds the FSM state encoding and the default debounce window.
package key_pkg;

    // 20 ms at 50 MHz: CNT_MAX + 1 clocks per window
    localparam int CNT_MAX_DEF = 999_999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILTER0 = 2'd1,
        DOWN    = 2'd2,
        FILTER1 = 2'd3
    } state_t;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the raw key plus a delay flop.
// Produces the synchronized level and its falling/rising edge strobes.
module key_sync_edge (
    input  logic Clk,
    input  logic Rst_n,
    input  logic key_in,
    output logic s2,
    output logic nedge,
    output logic pedge
);

    logic s1;
    logic d;

    // Synchronize key_in and keep one cycle of history; idle level is released
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            d  <= 1'b1;
        end else begin
            s1 <= key_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign nedge = d & ~s2;
    assign pedge = ~d & s2;

endmodule

// File: rtl/key_filter.sv
// Debounces a mechanical key: a level must hold for a full window
// before it is accepted, then a single key_flag pulse is emitted.
module key_filter
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

    logic s2;
    logic nedge;
    logic pedge;

    state_t state;
    state_t state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic flag_nx;
    logic kstate_nx;

    key_sync_edge u_sync (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .key_in(key_in),
        .s2    (s2),
        .nedge (nedge),
        .pedge (pedge)
    );

    // State, window counter and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b0;
            key_state <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            key_flag  <= flag_nx;
            key_state <= kstate_nx;
        end
    end

    // Next-state: an opposing edge always beats window expiry.
    // On acceptance key_state takes the filtered level, which is s2.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        flag_nx   = 1'b0;
        kstate_nx = key_state;
        unique case (state)
            IDLE: begin
                if (nedge) begin
                    state_nx = FILTER0;
                    cnt_nx   = '0;
                end
            end
            FILTER0: begin
                if (pedge) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_TOP) begin
                    state_nx  = DOWN;
                    cnt_nx    = '0;
                    flag_nx   = 1'b1;
                    kstate_nx = s2;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DOWN: begin
                if (pedge) begin
                    state_nx = FILTER1;
                    cnt_nx   = '0;
                end
            end
            FILTER1: begin
                if (nedge) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                end else if (cnt == CNT_TOP) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    flag_nx   = 1'b1;
                    kstate_nx = s2;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a 10-clock debounce window.
// Flags are logged with their edge number and compared to hand timing.
module tb_key_filter;
    import key_pkg::*;

    logic Clk = 1'b0;
    logic Rst_n;
    logic key_in;
    logic key_flag;
    logic key_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nflag = 0;
    int last_flag = -1;
    int dbl = 0;
    logic st_at_flag = 1'b1;
    logic prev_flag = 1'b0;
    int k;
    int f0;

    key_filter #(.CNT_MAX(9)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .key_in   (key_in),
        .key_flag (key_flag),
        .key_state(key_state)
    );

    always #5 Clk = ~Clk;

    // Edge counter: cyc = number of rising edges so far
    always @(posedge Clk) cyc <= cyc + 1;

    // Log every flag just after the edge that raised it
    always @(posedge Clk) begin
        #2;
        if (key_flag) begin
            nflag++;
            last_flag = cyc;
            st_at_flag = key_state;
            if (prev_flag) dbl++;
        end
        prev_flag = key_flag;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Rst_n  = 1'b0;
        key_in = 1'b1;
        tick(3);
        chk("rst_flag", 32'(key_flag), 0);
        chk("rst_state", 32'(key_state), 1);
        Rst_n = 1'b1;
        f0 = nflag;
        tick(50);
        chk("idle_noflag", nflag - f0, 0);
        chk("idle_state", 32'(key_state), 1);

        // clean press
        key_in = 1'b0;
        k = cyc + 1;
        f0 = nflag;
        tick(40);
        chk("press_cnt", nflag - f0, 1);
        chk("press_time", last_flag, k + 12);
        chk("press_st_at_flag", 32'(st_at_flag), 0);
        chk("press_state", 32'(key_state), 0);

        // clean release
        key_in = 1'b1;
        k = cyc + 1;
        f0 = nflag;
        tick(40);
        chk("rel_cnt", nflag - f0, 1);
        chk("rel_time", last_flag, k + 12);
        chk("rel_st_at_flag", 32'(st_at_flag), 1);
        chk("rel_state", 32'(key_state), 1);

        // short glitch low from IDLE
        f0 = nflag;
        key_in = 1'b0;
        tick(5);
        key_in = 1'b1;
        tick(30);
        chk("glitch_noflag", nflag - f0, 0);
        chk("glitch_state", 32'(key_state), 1);

        // bounce on press: low 4, high 3, low held
        f0 = nflag;
        key_in = 1'b0;
        tick(4);
        key_in = 1'b1;
        tick(3);
        key_in = 1'b0;
        k = cyc + 1;
        tick(40);
        chk("bounce_cnt", nflag - f0, 1);
        chk("bounce_time", last_flag, k + 12);
        chk("bounce_state", 32'(key_state), 0);

        key_in = 1'b1;
        f0 = nflag;
        tick(40);
        chk("bounce_rel_cnt", nflag - f0, 1);
        chk("bounce_rel_state", 32'(key_state), 1);

        // pedge lands on cnt==9: aborted
        f0 = nflag;
        key_in = 1'b0;
        tick(10);
        key_in = 1'b1;
        tick(40);
        chk("coinc_noflag", nflag - f0, 0);
        chk("coinc_state", 32'(key_state), 1);
        chk("coinc_fsm", 32'(dut.state), 32'(IDLE));

        // one clock longer: accepted, then released
        f0 = nflag;
        key_in = 1'b0;
        k = cyc + 1;
        tick(11);
        key_in = 1'b1;
        tick(40);
        chk("edge11_cnt", nflag - f0, 2);
        chk("edge11_time", last_flag, k + 23);
        chk("edge11_state", 32'(key_state), 1);

        // reset during FILTER0 at cnt==5
        key_in = 1'b0;
        tick(8);
        chk("mid_cnt", 32'(dut.cnt), 5);
        chk("mid_fsm", 32'(dut.state), 32'(FILTER0));
        #1;
        key_in = 1'b1;
        Rst_n = 1'b0;
        #1;
        chk("arst_flag", 32'(key_flag), 0);
        chk("arst_state", 32'(key_state), 1);
        chk("arst_cnt", 32'(dut.cnt), 0);
        chk("arst_fsm", 32'(dut.state), 32'(IDLE));
        @(negedge Clk);
        Rst_n = 1'b1;
        f0 = nflag;
        tick(30);
        chk("post_rst_noflag", nflag - f0, 0);
        chk("post_rst_state", 32'(key_state), 1);

        // reset in DOWN with key held, then fresh press
        key_in = 1'b0;
        tick(20);
        chk("down_state", 32'(key_state), 0);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("down_rst_state", 32'(key_state), 1);
        chk("down_rst_flag", 32'(key_flag), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        k = cyc + 1;
        f0 = nflag;
        tick(20);
        chk("held_cnt", nflag - f0, 1);
        chk("held_time", last_flag, k + 12);
        chk("held_state", 32'(key_state), 0);

        chk("no_double_flag", dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
